// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; the divide-by-zero case completes in a single cycle.
`default_nettype none

module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   sub_s, sub_t, rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic             unused_rem_msb;

   // After every restoring step R < D, so the top bit of R is never consumed.
   assign unused_rem_msb = rem_q[WIDTH];

   always_comb begin
      sub_s = {rem_q[WIDTH-1:0], quo_sh[WIDTH-1]};
      sub_t = sub_s - {1'b0, dvsr};
      if (!sub_t[WIDTH]) begin
         rem_nxt = sub_t;
         quo_nxt = {quo_sh[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = sub_s;
         quo_nxt = {quo_sh[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = (divisor == '0) ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (count == LAST) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q       <= '0;
         quo_sh      <= '0;
         dvsr        <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         rem_q  <= '0;
         quo_sh <= dividend;
         dvsr   <= divisor;
         count  <= '0;
         if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         rem_q  <= rem_nxt;
         quo_sh <= quo_nxt;
         count  <= count + CW'(1);
         if (count == LAST) begin
            quotient    <= quo_nxt;
            remainder   <= rem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=4), including an exhaustive sweep.
`default_nettype none

module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic       busy, done, div_by_zero;
   logic [3:0] quotient, remainder;

   int vectors = 0;
   int miscompares = 0;

   seq_divider #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation and returns start-to-done latency and whether busy behaved.
   // Operand inputs are scrambled after the start edge to prove they were captured.
   task automatic issue_and_wait(input logic [3:0] a, input logic [3:0] b,
                                 output int lat, output bit busy_ok);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      lat      = 1;
      busy_ok  = 1'b1;
      while (!done && lat < 20) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         lat++;
      end
      if (busy) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
         miscompares++;
         $display("FAIL reset_hold: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset[%0d]: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                     i, busy, done, quotient, remainder, div_by_zero);
         end
      end
   endtask

   task automatic test_basic();
      int lat;
      bit bok;
      issue_and_wait(4'd13, 4'd3, lat, bok);
      vectors++;
      if (lat !== 5 || !bok) begin
         miscompares++;
         $display("FAIL basic_timing: got latency=%0d busy_ok=%b, want 5 and 1", lat, bok);
      end
      vectors++;
      if ({quotient, remainder, div_by_zero} !== {4'd4, 4'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want q=4 r=1 dbz=0",
                  quotient, remainder, div_by_zero);
      end
      tick();
      vectors++;
      if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 4'd4, 4'd1}) begin
         miscompares++;
         $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d, want 0 0 4 1",
                  done, busy, quotient, remainder);
      end
   endtask

   task automatic test_edges();
      logic [3:0] ta [4] = '{4'd15, 4'd2, 4'd0, 4'd15};
      logic [3:0] tb [4] = '{4'd1,  4'd7, 4'd5, 4'd15};
      logic [3:0] tq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
      logic [3:0] tr [4] = '{4'd0,  4'd2, 4'd0, 4'd0};
      int lat;
      bit bok;
      for (int i = 0; i < 4; i++) begin
         issue_and_wait(ta[i], tb[i], lat, bok);
         vectors++;
         if (lat !== 5 || !bok || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL edge %0d/%0d: got lat=%0d busy_ok=%b q=%0d r=%0d dbz=%b, want lat=5 q=%0d r=%0d dbz=0",
                     ta[i], tb[i], lat, bok, quotient, remainder, div_by_zero, tq[i], tr[i]);
         end
         tick();
      end
   endtask

   task automatic test_div_zero();
      int lat;
      bit bok;
      issue_and_wait(4'd9, 4'd0, lat, bok);
      vectors++;
      if (lat !== 1 || !bok || {quotient, remainder, div_by_zero} !== {4'd15, 4'd9, 1'b1}) begin
         miscompares++;
         $display("FAIL div_zero: got lat=%0d busy_ok=%b q=%0d r=%0d dbz=%b, want lat=1 q=15 r=9 dbz=1",
                  lat, bok, quotient, remainder, div_by_zero);
      end
      tick();
      vectors++;
      if ({done, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL div_zero_pulse: got done=%b busy=%b, want 0 0", done, busy);
      end
      issue_and_wait(4'd8, 4'd2, lat, bok);
      vectors++;
      if (lat !== 5 || !bok || {quotient, remainder, div_by_zero} !== {4'd4, 4'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL after_zero 8/2: got lat=%0d busy_ok=%b q=%0d r=%0d dbz=%b, want lat=5 q=4 r=0 dbz=0",
                  lat, bok, quotient, remainder, div_by_zero);
      end
      tick();
   endtask

   task automatic test_start_in_run();
      int done_at = 0;
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (done && done_at == 0) done_at = k;
         if (k == 2) begin
            dividend = 4'd7;
            divisor  = 4'd2;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (k < 5) tick();
      end
      vectors++;
      if (done_at !== 5 || {quotient, remainder} !== {4'd4, 4'd1}) begin
         miscompares++;
         $display("FAIL start_in_run: got done_at=%0d q=%0d r=%0d, want done_at=5 q=4 r=1",
                  done_at, quotient, remainder);
      end
      tick();
      vectors++;
      if ({done, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL start_in_run_queued: got done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit bok;
      issue_and_wait(4'd13, 4'd3, lat, bok);
      issue_and_wait(4'd14, 4'd4, lat, bok);
      vectors++;
      if (lat !== 5 || !bok || {quotient, remainder, div_by_zero} !== {4'd3, 4'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL back_to_back 14/4: got lat=%0d busy_ok=%b q=%0d r=%0d dbz=%b, want lat=5 q=3 r=2 dbz=0",
                  lat, bok, quotient, remainder, div_by_zero);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      bit bok;
      bit saw_done = 1'b0;
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done || busy) saw_done = 1'b1;
      end
      vectors++;
      if (saw_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_no_done: got activity=%b, want 0", saw_done);
      end
      issue_and_wait(4'd6, 4'd4, lat, bok);
      vectors++;
      if (lat !== 5 || !bok || {quotient, remainder, div_by_zero} !== {4'd1, 4'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid 6/4: got lat=%0d busy_ok=%b q=%0d r=%0d dbz=%b, want lat=5 q=1 r=2 dbz=0",
                  lat, bok, quotient, remainder, div_by_zero);
      end
      tick();
   endtask

   task automatic test_sweep();
      int lat;
      bit bok;
      int exp_lat;
      logic [3:0] eq, er;
      logic edz;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) begin
               eq = 4'd15; er = 4'(a); edz = 1'b1; exp_lat = 1;
            end else begin
               eq = 4'(a / b); er = 4'(a % b); edz = 1'b0; exp_lat = 5;
            end
            issue_and_wait(4'(a), 4'(b), lat, bok);
            vectors++;
            if (lat !== exp_lat || !bok || {quotient, remainder, div_by_zero} !== {eq, er, edz}) begin
               miscompares++;
               $display("FAIL sweep %0d/%0d: got lat=%0d busy_ok=%b q=%0d r=%0d dbz=%b, want lat=%0d q=%0d r=%0d dbz=%b",
                        a, b, lat, bok, quotient, remainder, div_by_zero, exp_lat, eq, er, edz);
            end
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_div_zero();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider for the ALU datapath. It performs the inverse of the add/sub path: it produces quotient and remainder by repeated shift-and-subtract, one quotient bit per clock. It sits beside the adder/subtractor as the ALU's divide unit and uses a start/busy/done handshake toward the ALU control FSM.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (minimum 2)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a divide; sampled only in IDLE or DONE
dividend  input  WIDTH  unsigned numerator; captured on the accepted start edge
divisor  input  WIDTH  unsigned denominator; captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when results are valid
quotient  output  WIDTH  registered quotient; holds until the next accepted start
remainder  output  WIDTH  registered remainder; holds until the next accepted start
div_by_zero  output  1  registered flag for the last operation; set when divisor was 0

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high.
- Reset: when rst=1 at a rising edge, state goes to IDLE and busy, done, quotient, remainder and div_by_zero all become 0. Reset overrides every other event, including an operation in progress; a partial result is discarded.
- States:
  - IDLE: start=1 captures the operands. If divisor!=0, go to RUN with count=0. If divisor==0, go to DONE directly.
  - RUN: iterate. When count==WIDTH-1, the next state is DONE.
  - DONE: done=1 for exactly this cycle. With start=1, behave exactly as IDLE (back-to-back issue); otherwise go to IDLE.
- start in RUN is ignored. There is no queuing.
- Operand registers may change only on an accepted start. Input changes while busy have no effect.
- Internal registers: partial remainder R (WIDTH+1 bits, cleared to 0 on start), shift register Q (loaded with dividend), latched divisor D.
- Each RUN cycle performs one restoring step:
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}
  - T = S - {0,D}, computed in WIDTH+1 bits
  - If T[WIDTH]==0: R<=T and Q<={Q[WIDTH-2:0],1}
  - Else: R<=S and Q<={Q[WIDTH-2:0],0}
- RUN lasts exactly WIDTH cycles, counted by a count register of ceil(log2(WIDTH)) bits.
- Latency: start sampled at edge N.
  - busy=1 during cycles N+1..N+WIDTH.
  - done=1 in cycle N+WIDTH+1, with busy=0 in that same cycle.
  - Divide by zero: done=1 in cycle N+1 and busy never rises.
- Outputs are registered on entry to DONE:
  - Normal: quotient<=Q, remainder<=R[WIDTH-1:0], div_by_zero<=0.
  - Divide by zero: quotient<=all ones, remainder<=dividend, div_by_zero<=1.
- All values are unsigned. The result always satisfies dividend == quotient*divisor + remainder and remainder < divisor when divisor != 0.
- No X values are driven on any output in any state.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release, start=0 for 5 cycles -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 throughout.
- Basic divide, WIDTH=4: start with dividend=13, divisor=3 -> busy=1 for 4 cycles, then done=1 for one cycle with quotient=4, remainder=1, div_by_zero=0. Outputs hold afterwards.
- Edge values: 15/1 -> q=15 r=0. 2/7 -> q=0 r=2. 0/5 -> q=0 r=0. 15/15 -> q=1 r=0. Each case shows done exactly 5 cycles after its start edge.
- Divide by zero: dividend=9, divisor=0 -> done in the next cycle with quotient=15, remainder=9, div_by_zero=1, and busy stays 0. A following 8/2 -> q=4 r=0 with div_by_zero cleared.
- Handshake:
  - start pulsed again in the 2nd RUN cycle with different operands -> ignored; the first result (13/3 -> q=4 r=1) is delivered on schedule.
  - start held high in the DONE cycle with 14/4 -> accepted; the next done carries q=3 r=2.
- Reset mid-operation: assert rst in the 3rd RUN cycle of 13/3 -> next cycle all outputs are 0, no done pulse appears, and a new 6/4 afterwards yields q=1 r=2.
- Exhaustive sweep (self-checking): all 256 dividend/divisor pairs for WIDTH=4 -> compare each result against an integer reference model, and check the cycle count from start to done.
